// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the binary32 add/subtract datapath.
//   EXP_W / MAN_W / BIAS : IEEE-754 binary32 field widths and exponent bias
//   QNAN / POS_INF / NEG_INF : canonical special encodings
//   fp32_t               : packed {sign, exp, man} view of a binary32 word
//   MANT_EXT_W           : hidden bit + fraction + guard/round/sticky
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  // Hidden bit, fraction and three rounding bits (guard, round, sticky).
  localparam int MANT_EXT_W = MAN_W + 4;

  // All-ones exponent marks Inf/NaN.
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * BIAS + 1);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  function automatic logic fp_is_nan(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.man != '0);
  endfunction

  function automatic logic fp_is_inf(input fp32_t x);
    return (x.exp == EXP_MAX) && (x.man == '0);
  endfunction

endpackage

// File: rtl/lzc24.sv
// -----------------------------------------------------------------------------
// lzc24
// Leading-zero counter for the 24-bit significand extended with guard/round/
// sticky (27 bits total). Purely combinational.
//   i_vec : 27-bit vector, MSB is the hidden-bit position
//   o_cnt : number of leading zeros, 0..27 (27 when i_vec is all zero)
// -----------------------------------------------------------------------------
module lzc24
  import fpu_pkg::*;
(
  input  logic [MANT_EXT_W-1:0] i_vec,
  output logic [4:0]            o_cnt
);

  // Scan from LSB upward so the highest set bit is the last one to win.
  always_comb begin
    o_cnt = 5'(MANT_EXT_W);
    for (int i = 0; i < MANT_EXT_W; i++) begin
      if (i_vec[i]) begin
        o_cnt = 5'(MANT_EXT_W - 1 - i);
      end
    end
  end

endmodule

// File: rtl/add_sub_main.sv
// -----------------------------------------------------------------------------
// add_sub_main
// Single-cycle IEEE-754 binary32 adder/subtractor with one output register.
// Round to nearest, ties to even; full denormal support; canonical qNaN.
//   clk              : clock, rising edge
//   arst_n           : synchronous reset, active HIGH (loads R with +0)
//   a, b             : binary32 operands
//   operation_select : 0 = a + b, 1 = a - b
//   R                : registered result, valid one edge after the inputs
// There is no handshake: every cycle's inputs produce a result on the next
// edge; there is no valid/ready pair and no back-pressure.
// -----------------------------------------------------------------------------
module add_sub_main
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        arst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        operation_select,
  output logic [31:0] R
);

  // ---------------------------------------------------------------- unpack
  fp32_t w_a;
  fp32_t w_b;  // b with the effective (post-subtract) sign

  assign w_a = a;
  assign w_b = {b[31] ^ operation_select, b[30:0]};

  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  assign w_a_nan = fp_is_nan(w_a);
  assign w_b_nan = fp_is_nan(w_b);
  assign w_a_inf = fp_is_inf(w_a);
  assign w_b_inf = fp_is_inf(w_b);

  // --------------------------------------------------- order by magnitude
  // Comparing the raw {exp, man} bits orders finite magnitudes correctly,
  // denormals included. Ties keep a as the larger operand.
  logic  w_swap;
  fp32_t w_l;
  fp32_t w_s;

  assign w_swap = (w_b[30:0] > w_a[30:0]);
  assign w_l    = w_swap ? w_b : w_a;
  assign w_s    = w_swap ? w_a : w_b;

  // Exponent 0 behaves as exponent 1 with a hidden bit of 0.
  logic [EXP_W-1:0] w_l_exp;
  logic [EXP_W-1:0] w_s_exp;
  logic [MAN_W:0]   w_l_mant;
  logic [MAN_W:0]   w_s_mant;

  assign w_l_exp  = (w_l.exp == '0) ? EXP_W'(1) : w_l.exp;
  assign w_s_exp  = (w_s.exp == '0) ? EXP_W'(1) : w_s.exp;
  assign w_l_mant = {(w_l.exp != '0), w_l.man};
  assign w_s_mant = {(w_s.exp != '0), w_s.man};

  // ----------------------------------------------------------------- align
  // Shifting by 27 already pushes every significand bit into the sticky
  // region, so larger distances are clamped to 27.
  logic [EXP_W-1:0]        w_exp_diff;
  logic [4:0]              w_shamt;
  logic [2*MANT_EXT_W-1:0] w_s_wide;
  logic [MANT_EXT_W-1:0]   w_s_aligned;
  logic [MANT_EXT_W-1:0]   w_l_ext;

  assign w_exp_diff = w_l_exp - w_s_exp;
  assign w_shamt    = (w_exp_diff > EXP_W'(27)) ? 5'd27 : w_exp_diff[4:0];
  assign w_s_wide   = {w_s_mant, 3'b000, {MANT_EXT_W{1'b0}}} >> w_shamt;

  // Upper half is the aligned value; anything in the lower half folds into
  // the sticky (LSB) position.
  assign w_s_aligned = {w_s_wide[2*MANT_EXT_W-1:MANT_EXT_W+1],
                        w_s_wide[MANT_EXT_W] | (|w_s_wide[MANT_EXT_W-1:0])};
  assign w_l_ext     = {w_l_mant, 3'b000};

  // --------------------------------------------------------- add/subtract
  // The larger magnitude is always the minuend, so the difference is never
  // negative and the result takes the sign of the larger operand.
  logic                w_eff_sub;
  logic [MANT_EXT_W:0] w_sum;

  assign w_eff_sub = w_l.sign ^ w_s.sign;
  assign w_sum     = w_eff_sub ? ({1'b0, w_l_ext} - {1'b0, w_s_aligned})
                               : ({1'b0, w_l_ext} + {1'b0, w_s_aligned});

  // ------------------------------------------------------------- normalize
  logic [4:0]            w_lz;
  logic [EXP_W-1:0]      w_max_shift;
  logic [4:0]            w_norm_shift;
  logic [MANT_EXT_W-1:0] w_norm;
  logic [EXP_W:0]        w_exp_norm;

  lzc24 u_lzc (
    .i_vec (w_sum[MANT_EXT_W-1:0]),
    .o_cnt (w_lz)
  );

  // Left shifts stop once the exponent reaches 1; whatever is left is a
  // denormal (gradual underflow).
  assign w_max_shift  = w_l_exp - EXP_W'(1);
  assign w_norm_shift = ({3'b000, w_lz} <= w_max_shift) ? w_lz : w_max_shift[4:0];

  always_comb begin
    w_norm     = '0;
    w_exp_norm = '0;
    if (w_sum[MANT_EXT_W]) begin
      // Carry out: shift right one place, keeping the dropped bit as sticky.
      w_norm     = {w_sum[MANT_EXT_W:2], w_sum[1] | w_sum[0]};
      w_exp_norm = {1'b0, w_l_exp} + (EXP_W+1)'(1);
    end else begin
      w_norm     = w_sum[MANT_EXT_W-1:0] << w_norm_shift;
      w_exp_norm = {1'b0, w_l_exp} - {4'b0000, w_norm_shift};
    end
  end

  // A cleared hidden bit after the clamped shift means a denormal, which is
  // encoded with exponent field 0 (same scale as exponent 1).
  logic [EXP_W-1:0] w_exp_field;
  assign w_exp_field = w_norm[MANT_EXT_W-1] ? w_exp_norm[EXP_W-1:0] : '0;

  // ----------------------------------------------------------------- round
  // Nearest-even. Incrementing {exp, fraction} as one number lets a fraction
  // overflow bump the exponent: denormal -> normal and max finite -> Inf.
  logic        w_lsb, w_guard, w_sticky, w_round_up;
  logic [30:0] w_rounded;

  assign w_lsb      = w_norm[3];
  assign w_guard    = w_norm[2];
  assign w_sticky   = w_norm[1] | w_norm[0];
  assign w_round_up = w_guard & (w_sticky | w_lsb);
  assign w_rounded  = {w_exp_field, w_norm[MANT_EXT_W-2:3]} + {30'b0, w_round_up};

  // ---------------------------------------------------------- result select
  logic [31:0] w_result;

  always_comb begin
    w_result = '0;
    if (w_a_nan || w_b_nan) begin
      w_result = QNAN;
    end else if (w_a_inf && w_b_inf && (w_a.sign != w_b.sign)) begin
      w_result = QNAN;
    end else if (w_a_inf) begin
      w_result = w_a.sign ? NEG_INF : POS_INF;
    end else if (w_b_inf) begin
      w_result = w_b.sign ? NEG_INF : POS_INF;
    end else if (w_sum == '0) begin
      // Exact zero: -0 only when both effective signs are negative.
      w_result = {w_a.sign & w_b.sign, 31'b0};
    end else if (w_exp_norm >= {1'b0, EXP_MAX}) begin
      w_result = w_l.sign ? NEG_INF : POS_INF;
    end else begin
      w_result = {w_l.sign, w_rounded};
    end
  end

  // ------------------------------------------------------- output register
  logic [31:0] r_result;

  always_ff @(posedge clk) begin
    if (arst_n) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  assign R = r_result;

endmodule

// File: tb/tb_add_sub_main.sv
// -----------------------------------------------------------------------------
// tb_add_sub_main
// Directed checks of the binary32 add/subtract block. Inputs change on the
// falling edge; R is sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
module tb_add_sub_main;

  // ------------------------------------------------------ clock and reset
  logic        clk = 1'b0;
  logic        arst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        operation_select;
  logic [31:0] R;

  always #5 clk = ~clk;

  add_sub_main dut (
    .clk              (clk),
    .arst_n           (arst_n),
    .a                (a),
    .b                (b),
    .operation_select (operation_select),
    .R                (R)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // ------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] expected);
    tests_run++;
    assert (R === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: R=%08h expected %08h", tag, R, expected);
    end
  endtask

  // -------------------------------------------------------------- drivers
  // Apply one operation, wait for the capturing edge, then check R.
  task automatic op(input logic [31:0] va, input logic [31:0] vb,
                    input logic sel, input logic [31:0] expected,
                    input string tag);
    @(negedge clk);
    a = va;
    b = vb;
    operation_select = sel;
    @(posedge clk);
    #1;
    check(tag, expected);
  endtask

  // --------------------------------------------------------------- stimulus
  initial begin
    arst_n = 1'b1;
    a = 32'h4120_0000;
    b = 32'h40A0_0000;
    operation_select = 1'b0;

    // Reset with nonzero inputs must still give +0.
    @(posedge clk); #1;
    check("reset_0", 32'h0000_0000);
    @(negedge clk);
    a = 32'h7F7F_FFFF;
    b = 32'h3F80_0000;
    @(posedge clk); #1;
    check("reset_1", 32'h0000_0000);

    // Release: the first edge with reset low carries the applied operation.
    @(negedge clk);
    arst_n = 1'b0;
    a = 32'h4120_0000;
    b = 32'h40A0_0000;
    operation_select = 1'b0;
    @(posedge clk); #1;
    check("first_after_reset", 32'h4170_0000);

    // Basic arithmetic, back to back.
    op(32'h4160_0000, 32'h40A0_0000, 1'b1, 32'h4110_0000, "sub_14_5");
    op(32'h4120_0000, 32'h40A0_0000, 1'b1, 32'h40A0_0000, "sub_10_5");
    op(32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, "add_1_1");

    // Specials.
    op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, "inf_minus_inf");
    op(32'h7FC0_0000, 32'h4120_0000, 1'b0, 32'h7FC0_0000, "nan_a");
    op(32'h4120_0000, 32'h7FC0_0001, 1'b1, 32'h7FC0_0000, "nan_b");
    op(32'hFF80_0000, 32'h4120_0000, 1'b1, 32'hFF80_0000, "neg_inf_sub");
    op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, "inf_sub_inf");
    op(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000, "inf_add_inf");
    op(32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, "sub_neg_inf");

    // Overflow after rounding.
    op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, "ovf_pos");
    op(32'hFF7F_FFFF, 32'h7F7F_FFFF, 1'b1, 32'hFF80_0000, "ovf_neg");

    // Denormals. 0x00C38800 has exponent field 1: significands
    // 0xC38800 + 0x471000 = 0x10A9800 carry, giving exponent 2 with
    // significand 0x854C00.
    op(32'h0040_0000, 32'h0047_1000, 1'b0, 32'h0087_1000, "denorm_to_norm");
    op(32'h00C3_8800, 32'h0047_1000, 1'b0, 32'h0105_4C00, "denorm_carry");
    op(32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007F_FFFF, "gradual_uflow");
    op(32'h0000_0003, 32'h0000_0001, 1'b1, 32'h0000_0002, "denorm_sub");

    // Cancellation and signed zero.
    op(32'h4120_400A, 32'h4120_400A, 1'b1, 32'h0000_0000, "exact_cancel");
    op(32'h8000_0000, 32'hC0A0_0000, 1'b0, 32'hC0A0_0000, "negzero_add");
    op(32'h8000_0000, 32'hC120_0000, 1'b1, 32'h4120_0000, "negzero_sub");
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, "negzero_negzero");
    op(32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000, "negzero_sub_zero");
    op(32'h3F80_0000, 32'h0000_0000, 1'b1, 32'h3F80_0000, "x_sub_zero");
    op(32'hC0A0_0000, 32'hC0A0_0000, 1'b1, 32'h0000_0000, "neg_cancel");

    // Rounding ties to even.
    op(32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, "tie_even_down");
    op(32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, "tie_even_up");
    // 1 - 2^-25 lies halfway between 0x3F7FFFFF and 1.0; even picks 1.0.
    op(32'h3F80_0000, 32'h3300_0000, 1'b1, 32'h3F80_0000, "tie_after_norm");

    // Reset in mid-stream discards the in-flight result.
    @(negedge clk);
    arst_n = 1'b1;
    a = 32'h4120_0000;
    b = 32'h40A0_0000;
    operation_select = 1'b0;
    @(posedge clk); #1;
    check("mid_reset", 32'h0000_0000);
    @(negedge clk);
    arst_n = 1'b0;
    a = 32'h4160_0000;
    b = 32'h40A0_0000;
    operation_select = 1'b1;
    @(posedge clk); #1;
    check("after_mid_reset", 32'h4110_0000);
    op(32'h4120_0000, 32'h40A0_0000, 1'b0, 32'h4170_0000, "stream_resume");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
